poke_select_ctrl: RTL and testbench
===================================

POKE_SELECT_CTRL -- requirements
Module: poke_select_ctrl

Interface
REQ-001 Parameter NUM_SPRITES, 4, number of sprite renderers sharing the display slot; legal range 2..8.
REQ-002 Parameter HOME_X, 220, browse-mode sprite x origin (pixels).
REQ-003 Parameter HOME_Y, 140, sprite y origin (pixels), constant in all states.
REQ-004 Parameter TARGET_X, 40, x origin after slide; TARGET_X < HOME_X.
REQ-005 Parameter STEP, 4, slide distance per frame (pixels), 1..64.
REQ-006 Parameter AUTO_FRAMES, 120, idle frames before auto-advance (REQ-030 only).
REQ-007 clk  in  1  pixel clock; single clock domain; all logic on posedge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 x  in  10  current scan column from the VGA timing block.
REQ-010 y  in  9  current scan row from the VGA timing block.
REQ-011 btn_next  in  1  level button, already synchronized to clk; advance cursor.
REQ-012 btn_confirm  in  1  level button, already synchronized to clk; select/deselect.
REQ-013 chosen  out  NUM_SPRITES  one-hot enable per sprite renderer; all-zero blanks every sprite.
REQ-014 x0  out  10  sprite x origin, shared by all renderers.
REQ-015 y0  out  9  sprite y origin, shared by all renderers.
REQ-016 locked  out  1  high while the selected sprite is parked at TARGET_X.

Function
REQ-017 Rising edges of btn_next/btn_confirm shall be detected with one registered previous-sample; a press acts on state one cycle after the edge; held levels shall not repeat.
REQ-018 Frame tick shall be asserted for one cycle when x==0 and y==0; x0 changes only in the cycle following a tick.
REQ-019 FSM states: IDLE, BROWSE, SLIDE, LOCKED; exactly one state active.
REQ-020 IDLE: chosen=0, x0=HOME_X, locked=0; any press (next or confirm) -> BROWSE with cursor=0.
REQ-021 BROWSE: chosen=one-hot(cursor), x0=HOME_X; btn_next edge increments cursor, wrapping NUM_SPRITES-1 -> 0.
REQ-022 BROWSE: btn_confirm edge -> SLIDE; cursor frozen.
REQ-023 Simultaneous next and confirm edges in BROWSE: confirm wins, cursor unchanged.
REQ-024 SLIDE: on each tick x0 <= x0-STEP; if x0-STEP <= TARGET_X, x0 <= TARGET_X and state -> LOCKED on same update.
REQ-025 SLIDE: btn_next and btn_confirm edges ignored (not queued).
REQ-026 LOCKED: locked=1, x0=TARGET_X, chosen unchanged; btn_confirm edge -> BROWSE with x0=HOME_X, cursor retained; btn_next ignored.
REQ-027 y0 shall equal HOME_Y at all times after reset.
REQ-028 Subtraction performed at 11 bits; no x0 underflow/wrap permitted for any legal parameter set.

Reset
REQ-029 rst high at any clock edge, including mid-SLIDE: state=IDLE, cursor=0, chosen=0, x0=HOME_X, y0=HOME_Y, locked=0, button history=0, auto counter=0; a button held through reset release shall not produce an edge.

Configuration
REQ-030 Macro POKE_AUTOCYCLE_EN: when defined, BROWSE counts ticks with no button edge; at AUTO_FRAMES ticks cursor advances (wrapping) and counter clears; any edge or leaving BROWSE clears counter. When undefined, no counter exists and cursor moves only on btn_next.

Verification
REQ-031 Reset, pulse btn_next 1 cycle -> after 1 cycle state BROWSE, chosen=0001, x0=220, y0=140.
REQ-032 From BROWSE cursor=3, btn_next edge -> chosen=0001; hold btn_next 1000 cycles -> no further change.
REQ-033 BROWSE cursor=1, confirm; drive 45 frame ticks -> x0 steps 216,212,...,44, then 40 with locked=1 on tick 45; chosen=0010 throughout.
REQ-034 Same-cycle next+confirm edges in BROWSE cursor=2 -> SLIDE, chosen=0100.
REQ-035 Assert rst during SLIDE at x0=100 -> next cycle IDLE, chosen=0, x0=220, locked=0.
REQ-036 With POKE_AUTOCYCLE_EN, BROWSE cursor=0, 120 ticks no presses -> chosen=0010; press at tick 119 -> counter restarts, no auto advance.

Source files
------------

// File: rtl/poke_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : poke_select_ctrl
// Description: Sprite select/slide controller: browse a cursor over sprite
//              renderers, confirm to slide the chosen one to a parked slot.
//              Optional macro POKE_AUTOCYCLE_EN enables idle auto-advance.
// Revision   : 1.0 - initial release
// ============================================================================
module poke_select_ctrl #(
   parameter int NUM_SPRITES = 4,
   parameter int HOME_X      = 220,
   parameter int HOME_Y      = 140,
   parameter int TARGET_X    = 40,
   parameter int STEP        = 4,
   parameter int AUTO_FRAMES = 120
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [9:0]             x,
   input  logic [8:0]             y,
   input  logic                   btn_next,
   input  logic                   btn_confirm,
   output logic [NUM_SPRITES-1:0] chosen,
   output logic [9:0]             x0,
   output logic [8:0]             y0,
   output logic                   locked
);

   localparam int CW = $clog2(NUM_SPRITES);
   localparam logic [CW-1:0] c_CURSOR_LAST = CW'(NUM_SPRITES - 1);
   localparam logic [9:0]    c_HOME_X      = 10'(HOME_X);
   localparam logic [8:0]    c_HOME_Y      = 9'(HOME_Y);
   localparam logic [9:0]    c_TARGET_X    = 10'(TARGET_X);
   localparam logic [10:0]   c_TARGET_X11  = 11'(TARGET_X);
   localparam logic [10:0]   c_STEP11      = 11'(STEP);

   generate
      if ((NUM_SPRITES < 2) || (NUM_SPRITES > 8)) begin : g_chk_num
         $error("poke_select_ctrl: NUM_SPRITES out of range 2..8");
      end
      if ((STEP < 1) || (STEP > 64)) begin : g_chk_step
         $error("poke_select_ctrl: STEP out of range 1..64");
      end
      if (TARGET_X >= HOME_X) begin : g_chk_target
         $error("poke_select_ctrl: TARGET_X must be below HOME_X");
      end
      if (AUTO_FRAMES < 1) begin : g_chk_auto
         $error("poke_select_ctrl: AUTO_FRAMES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BROWSE = 2'd1,
      S_SLIDE  = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cursor, w_cursor_next, w_cursor_inc;
   logic [9:0]    r_x0, w_x0_next;
   logic          r_next_prev, r_conf_prev, r_armed;
   logic          w_next_edge, w_conf_edge, w_tick;
   logic [10:0]   w_sub;

   // r_armed masks edges for the first cycle after reset so a button held
   // through reset release is absorbed into the history, not seen as a press.
   assign w_next_edge  = r_armed & btn_next    & ~r_next_prev;
   assign w_conf_edge  = r_armed & btn_confirm & ~r_conf_prev;
   assign w_tick       = (x == 10'd0) && (y == 9'd0);
   assign w_sub        = {1'b0, r_x0} - c_STEP11;
   assign w_cursor_inc = (r_cursor == c_CURSOR_LAST) ? '0 : r_cursor + 1'b1;

`ifdef POKE_AUTOCYCLE_EN
   localparam int CNTW = $clog2(AUTO_FRAMES + 1);
   localparam logic [CNTW-1:0] c_AUTO_LAST = CNTW'(AUTO_FRAMES - 1);
   logic [CNTW-1:0] r_auto_cnt, w_auto_cnt_next;

   always_ff @(posedge clk) begin
      if (rst) r_auto_cnt <= '0;
      else     r_auto_cnt <= w_auto_cnt_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cursor    <= '0;
         r_x0        <= c_HOME_X;
         r_next_prev <= 1'b0;
         r_conf_prev <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cursor    <= w_cursor_next;
         r_x0        <= w_x0_next;
         r_next_prev <= btn_next;
         r_conf_prev <= btn_confirm;
         r_armed     <= 1'b1;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cursor_next = r_cursor;
      w_x0_next     = r_x0;
`ifdef POKE_AUTOCYCLE_EN
      w_auto_cnt_next = '0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_next_edge || w_conf_edge) begin
               w_state_next  = S_BROWSE;
               w_cursor_next = '0;
            end
         end
         S_BROWSE: begin
            // Confirm has priority over a coincident next edge.
            if (w_conf_edge) begin
               w_state_next = S_SLIDE;
            end else if (w_next_edge) begin
               w_cursor_next = w_cursor_inc;
            end
`ifdef POKE_AUTOCYCLE_EN
            else if (w_tick) begin
               if (r_auto_cnt == c_AUTO_LAST) begin
                  w_cursor_next = w_cursor_inc;
               end else begin
                  w_auto_cnt_next = r_auto_cnt + 1'b1;
               end
            end else begin
               w_auto_cnt_next = r_auto_cnt;
            end
`endif
         end
         S_SLIDE: begin
            // Bit 10 of the 11-bit difference flags a borrow past zero.
            if (w_tick) begin
               if (w_sub[10] || (w_sub <= c_TARGET_X11)) begin
                  w_x0_next    = c_TARGET_X;
                  w_state_next = S_LOCKED;
               end else begin
                  w_x0_next = w_sub[9:0];
               end
            end
         end
         S_LOCKED: begin
            if (w_conf_edge) begin
               w_state_next = S_BROWSE;
               w_x0_next    = c_HOME_X;
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_cursor_next = '0;
            w_x0_next     = c_HOME_X;
         end
      endcase
   end

   assign chosen = (r_state == S_IDLE) ? '0 : (NUM_SPRITES'(1) << r_cursor);
   assign x0     = r_x0;
   assign y0     = c_HOME_Y;
   assign locked = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_poke_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_poke_select_ctrl
// Description: Directed self-checking bench for poke_select_ctrl (default
//              parameters); covers POKE_AUTOCYCLE_EN when the macro is set.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_poke_select_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] x   = 10'd5;
   logic [8:0] y   = 9'd5;
   logic       btn_next    = 1'b0;
   logic       btn_confirm = 1'b0;
   logic [3:0] chosen;
   logic [9:0] x0;
   logic [8:0] y0;
   logic       locked;

   int n_tests = 0;
   int n_fail  = 0;

   poke_select_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .x           (x),
      .y           (y),
      .btn_next    (btn_next),
      .btn_confirm (btn_confirm),
      .chosen      (chosen),
      .x0          (x0),
      .y0          (y0),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_next();
      btn_next = 1'b1;
      @(negedge clk);
      btn_next = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_confirm();
      btn_confirm = 1'b1;
      @(negedge clk);
      btn_confirm = 1'b0;
      @(negedge clk);
   endtask

   task automatic tick();
      x = 10'd0;
      y = 9'd0;
      @(negedge clk);
      x = 10'd5;
      y = 9'd5;
   endtask

   initial begin
      // Reset with btn_next held through release
      @(negedge clk);
      rst      = 1'b1;
      btn_next = 1'b1;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_chosen", 32'(chosen), 32'd0);
      chk("rst_x0",     32'(x0),     32'd220);
      chk("rst_y0",     32'(y0),     32'd140);
      chk("rst_locked", 32'(locked), 32'd0);
      step(1);
      chk("held_through_rst_chosen", 32'(chosen), 32'd0);
      btn_next = 1'b0;
      step(2);

      // First press enters browse at cursor 0
      btn_next = 1'b1;
      @(negedge clk);
      btn_next = 1'b0;
      chk("browse_chosen", 32'(chosen), 32'b0001);
      chk("browse_x0",     32'(x0),     32'd220);
      chk("browse_y0",     32'(y0),     32'd140);
      chk("browse_locked", 32'(locked), 32'd0);
      @(negedge clk);

      press_next(); chk("cur1", 32'(chosen), 32'b0010);
      press_next(); chk("cur2", 32'(chosen), 32'b0100);
      press_next(); chk("cur3", 32'(chosen), 32'b1000);

      // Wrap from cursor 3, then hold with no repeat
      btn_next = 1'b1;
      @(negedge clk);
      chk("wrap", 32'(chosen), 32'b0001);
      step(1000);
      chk("hold_no_repeat", 32'(chosen), 32'b0001);
      btn_next = 1'b0;
      step(1);

      press_next(); chk("cur1_again", 32'(chosen), 32'b0010);

      // Confirm and slide 45 frames
      press_confirm();
      chk("slide_chosen", 32'(chosen), 32'b0010);
      chk("slide_x0_before_tick", 32'(x0), 32'd220);
      press_next();
      chk("slide_next_ignored", 32'(chosen), 32'b0010);
      press_confirm();
      chk("slide_conf_ignored", 32'(locked), 32'd0);
      for (int i = 1; i <= 45; i++) begin
         tick();
         chk($sformatf("slide_x0_t%0d", i), 32'(x0), (i == 45) ? 32'd40 : 32'(220 - 4 * i));
         chk($sformatf("slide_lock_t%0d", i), 32'(locked), (i == 45) ? 32'd1 : 32'd0);
         chk($sformatf("slide_sel_t%0d", i), 32'(chosen), 32'b0010);
         step(2);
      end

      // Locked: next ignored, ticks hold x0, confirm returns to browse
      press_next();
      chk("locked_next_ignored", 32'(chosen), 32'b0010);
      chk("locked_still", 32'(locked), 32'd1);
      tick();
      chk("locked_x0_hold", 32'(x0), 32'd40);
      step(1);
      press_confirm();
      chk("unlock_x0",     32'(x0),     32'd220);
      chk("unlock_locked", 32'(locked), 32'd0);
      chk("unlock_cursor", 32'(chosen), 32'b0010);

      // Simultaneous next+confirm at cursor 2: confirm wins
      press_next();
      chk("pre_simul_cur2", 32'(chosen), 32'b0100);
      btn_next    = 1'b1;
      btn_confirm = 1'b1;
      @(negedge clk);
      btn_next    = 1'b0;
      btn_confirm = 1'b0;
      @(negedge clk);
      chk("simul_chosen", 32'(chosen), 32'b0100);
      tick();
      chk("simul_in_slide", 32'(x0), 32'd216);
      for (int i = 0; i < 29; i++) begin
         step(1);
         tick();
      end
      chk("slide_at_100", 32'(x0), 32'd100);

      // Reset mid-slide
      rst = 1'b1;
      step(1);
      chk("midrst_chosen", 32'(chosen), 32'd0);
      chk("midrst_x0",     32'(x0),     32'd220);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_y0",     32'(y0),     32'd140);
      rst = 1'b0;
      step(2);

      press_next();
      chk("auto_start", 32'(chosen), 32'b0001);
`ifdef POKE_AUTOCYCLE_EN
      for (int i = 0; i < 119; i++) tick();
      chk("auto_t119", 32'(chosen), 32'b0001);
      tick();
      chk("auto_t120", 32'(chosen), 32'b0010);
      for (int i = 0; i < 119; i++) tick();
      press_next();
      chk("auto_press_t119", 32'(chosen), 32'b0100);
      tick();
      chk("auto_restart_no_adv", 32'(chosen), 32'b0100);
      for (int i = 0; i < 118; i++) tick();
      chk("auto_restart_t119", 32'(chosen), 32'b0100);
      tick();
      chk("auto_restart_t120", 32'(chosen), 32'b1000);
`else
      for (int i = 0; i < 130; i++) tick();
      chk("no_auto_advance", 32'(chosen), 32'b0001);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
